overload_frame: RTL
===================

OVERLOAD_FRAME -- requirements
Module: overload_frame

Interface
REQ-001 The block SHALL have a port samplePoint, input, 1 bit: the single clock; all state updates on its rising edge; one edge = one CAN bit sample.
REQ-002 The block SHALL have a port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have a port canRX, input, 1 bit: sampled bus level (0 = dominant, 1 = recessive).
REQ-004 The block SHALL have a port isOverload, input, 1 bit: overload request from the interframe-space detector.
REQ-005 The block SHALL have a port canTX, output, 1 bit: transmit level; idle value 1.
REQ-006 The block SHALL have a port overloadActive, output, 1 bit: high whenever the state is not IDLE.
REQ-007 The block SHALL have a port endOverload, output, 1 bit: one-sample pulse on overload delimiter completion; it feeds the interframe-space detector.
REQ-008 The block SHALL have a port bitError, output, 1 bit: one-sample pulse when recessive is read back during its own flag.
REQ-009 The block SHALL have a port formError, output, 1 bit: one-sample pulse on a delimiter violation or an excessive dominant extension.

Function
REQ-010 The block SHALL implement four states: IDLE, FLAG, WAIT_REC, DELIM.
REQ-011 IDLE: on a sample with isOverload=1, the block SHALL go to FLAG, set canTX<=0 and clear the bit counter; isOverload in any other state SHALL be ignored.
REQ-012 FLAG: the block SHALL hold canTX=0 for exactly 6 samples; at each sample canRX=0 increments the counter.
REQ-013 FLAG, 6th sample: the block SHALL set canTX<=1, go to WAIT_REC and clear the counter.
REQ-014 FLAG, sample with canRX=1: the block SHALL pulse bitError, set canTX<=1 and go to IDLE.
REQ-015 WAIT_REC, canRX=0 (other nodes' flag superposition): the block SHALL increment the counter; on the 7th consecutive dominant it SHALL pulse formError and go to IDLE.
REQ-016 WAIT_REC, canRX=1: the block SHALL go to DELIM with counter=1, since the first recessive counts as delimiter bit 1.
REQ-017 DELIM, canRX=1: the block SHALL increment the counter; on reaching 8 it SHALL pulse endOverload for one sample and go to IDLE.
REQ-018 DELIM, canRX=0: the block SHALL pulse formError and go to IDLE; no endOverload is produced.
REQ-019 All outputs SHALL be registered, and each pulse output SHALL be high for exactly one samplePoint period.
REQ-020 The bit counter SHALL be 4 bits wide and SHALL never wrap: every terminal count forces a state exit.
REQ-021 When isOverload=1 on the same sample as endOverload, the block SHALL return to IDLE first; a new request is accepted on the next sample only.

Reset
REQ-022 Asserting reset SHALL immediately force state IDLE, counter 0, canTX=1, and overloadActive, endOverload, bitError and formError to 0, including mid-flag.
REQ-023 After reset is released, the block SHALL take no action until the first isOverload sample.

Structure
REQ-024 A shared package can_pkg SHALL hold the state encoding and the constants FLAG_LEN=6, DELIM_LEN=8 and MAX_EXTRA_DOM=7.
REQ-025 The block SHALL instantiate one sub-module, bit_counter: a 4-bit counter with clear, enable and terminal-compare, reused later by the error-frame block.

Verification
REQ-026 The bench SHALL cover the nominal case: isOverload pulse at edge E0, canRX=canTX delayed one sample -> canTX=0 on E0..E6, endOverload high E14..E15, overloadActive low after E14.
REQ-027 The bench SHALL cover superposition: canRX held 0 for 3 extra samples after E6, then 1 -> endOverload at E17.
REQ-028 The bench SHALL cover excessive dominant: canRX=0 for 7 samples after E6 -> formError at E13, no endOverload.
REQ-029 The bench SHALL cover a flag bit error: canRX=1 at E3 -> bitError at E3, canTX=1 from E3.
REQ-030 The bench SHALL cover a delimiter violation: canRX=0 on the 4th delimiter sample -> formError pulse, IDLE.
REQ-031 The bench SHALL cover reset mid-FLAG: reset asserted at E2 -> canTX=1 at once; a later isOverload restarts a full 6-bit flag.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN frame-control definitions: state encoding and bit-length constants
// used by the overload and error frame blocks.
package can_pkg;

    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] FLAG_LEN      = 4'd6;
    localparam logic [CNT_W-1:0] DELIM_LEN     = 4'd8;
    localparam logic [CNT_W-1:0] MAX_EXTRA_DOM = 4'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLAG     = 2'd1,
        WAIT_REC = 2'd2,
        DELIM    = 2'd3
    } frameState_t;

endpackage

// File: rtl/bit_counter.sv
// Small CAN bit counter with clear, enable and a terminal compare that flags
// the sample whose increment would reach the programmed limit.
module bit_counter
    import can_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             lastStep
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // clear together with enable restarts the count with the current bit already counted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= enable ? ONE : '0;
        end else if (enable && (count != '1)) begin
            count <= count + ONE;
        end
    end

    assign lastStep = (count == (limit - ONE));

endmodule

// File: rtl/overload_frame.sv
// CAN overload frame generator: sends the 6-bit dominant overload flag, tolerates
// flag superposition from other nodes and checks the 8-bit recessive delimiter.
module overload_frame
    import can_pkg::*;
(
    input  logic samplePoint,
    input  logic reset,
    input  logic canRX,
    input  logic isOverload,
    output logic canTX,
    output logic overloadActive,
    output logic endOverload,
    output logic bitError,
    output logic formError
);

    frameState_t      state;
    frameState_t      nextState;
    logic             nextCanTX;
    logic             nextEnd;
    logic             nextBitErr;
    logic             nextFormErr;
    logic             cntClear;
    logic             cntEnable;
    logic             cntLast;
    logic [CNT_W-1:0] cntLimit;

    bit_counter bitCount (
        .clock    (samplePoint),
        .reset    (reset),
        .clear    (cntClear),
        .enable   (cntEnable),
        .limit    (cntLimit),
        .lastStep (cntLast)
    );

    always_ff @(posedge samplePoint or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            canTX          <= 1'b1;
            overloadActive <= 1'b0;
            endOverload    <= 1'b0;
            bitError       <= 1'b0;
            formError      <= 1'b0;
        end else begin
            state          <= nextState;
            canTX          <= nextCanTX;
            overloadActive <= (nextState != IDLE);
            endOverload    <= nextEnd;
            bitError       <= nextBitErr;
            formError      <= nextFormErr;
        end
    end

    // Every terminal count leaves its state, so the counter never runs past its limit.
    always_comb begin
        nextState   = state;
        nextCanTX   = canTX;
        nextEnd     = 1'b0;
        nextBitErr  = 1'b0;
        nextFormErr = 1'b0;
        cntClear    = 1'b0;
        cntEnable   = 1'b0;
        cntLimit    = FLAG_LEN;

        case (state)
            IDLE: begin
                nextCanTX = 1'b1;
                if (isOverload) begin
                    nextState = FLAG;
                    nextCanTX = 1'b0;
                    cntClear  = 1'b1;
                end
            end

            FLAG: begin
                cntLimit = FLAG_LEN;
                if (canRX) begin
                    nextBitErr = 1'b1;
                    nextCanTX  = 1'b1;
                    nextState  = IDLE;
                    cntClear   = 1'b1;
                end else if (cntLast) begin
                    nextCanTX = 1'b1;
                    nextState = WAIT_REC;
                    cntClear  = 1'b1;
                end else begin
                    cntEnable = 1'b1;
                end
            end

            WAIT_REC: begin
                cntLimit = MAX_EXTRA_DOM;
                if (canRX) begin
                    // the first recessive sample is already delimiter bit 1
                    nextState = DELIM;
                    cntClear  = 1'b1;
                    cntEnable = 1'b1;
                end else if (cntLast) begin
                    nextFormErr = 1'b1;
                    nextState   = IDLE;
                    cntClear    = 1'b1;
                end else begin
                    cntEnable = 1'b1;
                end
            end

            DELIM: begin
                cntLimit = DELIM_LEN;
                if (!canRX) begin
                    nextFormErr = 1'b1;
                    nextState   = IDLE;
                    cntClear    = 1'b1;
                end else if (cntLast) begin
                    nextEnd   = 1'b1;
                    nextState = IDLE;
                    cntClear  = 1'b1;
                end else begin
                    cntEnable = 1'b1;
                end
            end

            default: begin
                nextState = IDLE;
                nextCanTX = 1'b1;
                cntClear  = 1'b1;
            end
        endcase
    end

endmodule
